// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period and high time of a slow, asynchronous,
// clock-like input in fast clk cycles. It works either as a single shot or
// continuously, and returns to IDLE on timeout or abort.
module clk_period_meter #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, MEASURE} state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, prev, rise, fall;

  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] hi_r, hi_d;
  logic             cont_r, cont_d;
  logic [CNT_W-1:0] period_d, high_d;
  logic             valid_d, timeout_d;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev;
  assign fall = ~s & prev;

  // Bring sig_in into the clk domain and keep one cycle of history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev   <= s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state: abort wins over everything, then a rise event, then the timeout.
  always_comb begin
    state_d = state;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:       if (start) state_d = WAIT_FIRST;
        WAIT_FIRST: begin
          if (rise)            state_d = MEASURE;
          else if (cnt == TMO) state_d = IDLE;
        end
        MEASURE: begin
          if (rise)            state_d = cont_r ? MEASURE : IDLE;
          else if (cnt == TMO) state_d = IDLE;
        end
        default:               state_d = IDLE;
      endcase
    end
  end

  // Counter, high-time capture and result values for the coming cycle.
  always_comb begin
    cnt_d     = cnt;
    hi_d      = hi_r;
    cont_d    = cont_r;
    period_d  = period;
    high_d    = high_time;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    if (!abort) begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt_d  = ONE;
            cont_d = cont;
          end
        end
        WAIT_FIRST: begin
          if (rise) begin
            cnt_d = ONE;
            hi_d  = '0;
          end else if (cnt == TMO) begin
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt + ONE;
          end
        end
        MEASURE: begin
          if (fall) hi_d = cnt;
          if (rise) begin
            period_d = cnt;
            high_d   = hi_r;
            valid_d  = 1'b1;
            cnt_d    = ONE;
            hi_d     = '0;
          end else if (cnt == TMO) begin
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Register the datapath and outputs so busy/valid/timeout come out glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      hi_r      <= '0;
      cont_r    <= 1'b0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cnt       <= cnt_d;
      hi_r      <= hi_d;
      cont_r    <= cont_d;
      period    <= period_d;
      high_time <= high_d;
      valid     <= valid_d;
      timeout   <= timeout_d;
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: drives two meters (TIMEOUT=100/2 sync stages and
// TIMEOUT=10/3 sync stages) with the same waveforms. It checks them every cycle
// against a timestamp-based model, plus literal expectations for key scenarios.
module tb_clk_period_meter;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst, sig_in, start, cont, abort;

  logic             busy_a, valid_a, timeout_a;
  logic [CNT_W-1:0] period_a, high_a;
  logic             busy_b, valid_b, timeout_b;
  logic [CNT_W-1:0] period_b, high_b;

  int checks = 0;
  int failures = 0;
  int vcnt_a = 0, vcnt_b = 0, tcnt_a = 0, tcnt_b = 0;

  bit wave_en = 1'b0;
  bit noise = 1'b0;
  int hi_len = 5, lo_len = 5, phase = 0;

  // Model state, index 0 = dut_a, 1 = dut_b. Timestamps are edge numbers.
  int     m_tmo[2]  = '{100, 10};
  int     m_sync[2] = '{2, 3};
  int     m_state[2];
  longint m_ts[2], m_r0[2], m_fall[2];
  bit     m_cont[2];
  longint m_period[2], m_high[2];
  bit     m_valid[2], m_timeout[2], m_busy[2];
  bit     m_hist[2][8];
  longint n_edge;

  clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(100), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont), .abort(abort),
    .busy(busy_a), .valid(valid_a), .period(period_a), .high_time(high_a), .timeout(timeout_a)
  );

  clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(10), .SYNC_STAGES(3)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont), .abort(abort),
    .busy(busy_b), .valid(valid_b), .period(period_b), .high_time(high_b), .timeout(timeout_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit ct, input bit ab);
    @(negedge clk);
    start = st;
    cont  = ct;
    abort = ab;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic set_wave(input int hi, input int lo);
    wave_en = 1'b1;
    noise   = 1'b0;
    hi_len  = hi;
    lo_len  = lo;
    phase   = 0;
  endtask

  // Behavioural model: the synchronizer is a pure delay; period and high time
  // are differences between edge timestamps of the delayed signal.
  always @(posedge clk or posedge rst) begin : model
    bit s_now, s_prev, rise, fall;
    if (rst) begin
      n_edge = 0;
      for (int i = 0; i < 2; i++) begin
        m_state[i] = 0; m_cont[i] = 1'b0; m_period[i] = 0; m_high[i] = 0;
        m_valid[i] = 1'b0; m_timeout[i] = 1'b0; m_busy[i] = 1'b0;
        m_ts[i] = 0; m_r0[i] = 0; m_fall[i] = -1;
        for (int k = 0; k < 8; k++) m_hist[i][k] = 1'b0;
      end
    end else begin
      n_edge++;
      for (int i = 0; i < 2; i++) begin
        s_now  = m_hist[i][m_sync[i]-1];
        s_prev = m_hist[i][m_sync[i]];
        rise   = s_now & ~s_prev;
        fall   = ~s_now & s_prev;
        m_valid[i]   = 1'b0;
        m_timeout[i] = 1'b0;
        if (abort) begin
          m_state[i] = 0;
        end else if (m_state[i] == 0) begin
          if (start) begin
            m_state[i] = 1; m_ts[i] = n_edge; m_cont[i] = cont;
          end
        end else if (m_state[i] == 1) begin
          if (rise) begin
            m_state[i] = 2; m_r0[i] = n_edge; m_fall[i] = -1;
          end else if (n_edge - m_ts[i] == longint'(m_tmo[i])) begin
            m_timeout[i] = 1'b1; m_state[i] = 0;
          end
        end else begin
          if (fall) m_fall[i] = n_edge;
          if (rise) begin
            m_period[i] = n_edge - m_r0[i];
            m_high[i]   = (m_fall[i] < 0) ? 0 : m_fall[i] - m_r0[i];
            m_valid[i]  = 1'b1;
            m_r0[i]     = n_edge;
            m_fall[i]   = -1;
            if (!m_cont[i]) m_state[i] = 0;
          end else if (n_edge - m_r0[i] == longint'(m_tmo[i])) begin
            m_timeout[i] = 1'b1; m_state[i] = 0;
          end
        end
        m_busy[i] = (m_state[i] != 0);
        for (int k = 7; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = sig_in;
      end
    end
  end

  // Compare both DUTs against the model just after every clock edge.
  initial begin : compare
    forever begin
      @(posedge clk);
      #1;
      checkOutput("cyc_busy_a",    busy_a,    m_busy[0]);
      checkOutput("cyc_valid_a",   valid_a,   m_valid[0]);
      checkOutput("cyc_timeout_a", timeout_a, m_timeout[0]);
      checkOutput("cyc_period_a",  period_a,  m_period[0]);
      checkOutput("cyc_high_a",    high_a,    m_high[0]);
      checkOutput("cyc_busy_b",    busy_b,    m_busy[1]);
      checkOutput("cyc_valid_b",   valid_b,   m_valid[1]);
      checkOutput("cyc_timeout_b", timeout_b, m_timeout[1]);
      checkOutput("cyc_period_b",  period_b,  m_period[1]);
      checkOutput("cyc_high_b",    high_b,    m_high[1]);
      if (valid_a === 1'b1)   vcnt_a++;
      if (valid_b === 1'b1)   vcnt_b++;
      if (timeout_a === 1'b1) tcnt_a++;
      if (timeout_b === 1'b1) tcnt_b++;
    end
  end

  // Waveform source on sig_in: square wave of hi_len/lo_len or random noise.
  initial begin : wave_gen
    forever begin
      @(negedge clk);
      if (wave_en) begin
        if (noise) begin
          sig_in = 1'($urandom_range(0, 1));
        end else begin
          sig_in = (phase < hi_len);
          phase  = (phase + 1) % (hi_len + lo_len);
        end
      end
    end
  end

  // Hard stop in case something never finishes.
  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized ones.
  initial begin : main
    bit got;
    int ta, tb, r;
    rst = 1'b1; sig_in = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy",    busy_a,    0);
    checkOutput("reset_valid",   valid_a,   0);
    checkOutput("reset_timeout", timeout_a, 0);
    checkOutput("reset_period",  period_a,  0);
    checkOutput("reset_high",    high_a,    0);
    rst = 1'b0;

    // Single shot on a 5/5 wave.
    set_wave(5, 5);
    repeat (20) @(negedge clk);
    vcnt_a = 0; vcnt_b = 0; tcnt_b = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (valid_a) begin
        got = 1'b1;
        checkOutput("single_busy_at_valid", busy_a, 0);
      end
    end
    checkOutput("single_valid_seen", got, 1);
    repeat (30) @(negedge clk);
    checkOutput("single_vcnt_a",  vcnt_a,   1);
    checkOutput("single_period",  period_a, 10);
    checkOutput("single_high",    high_a,   5);
    checkOutput("edge_vcnt_b",    vcnt_b,   1);
    checkOutput("edge_period_b",  period_b, 10);
    checkOutput("edge_high_b",    high_b,   5);
    checkOutput("edge_no_tmo_b",  tcnt_b,   0);

    // Continuous mode, then abort.
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (30) @(negedge clk);
    vcnt_a = 0; vcnt_b = 0;
    repeat (50) @(negedge clk);
    checkOutput("cont_vcnt_a",   vcnt_a,   5);
    checkOutput("cont_vcnt_b",   vcnt_b,   5);
    checkOutput("cont_period_a", period_a, 10);
    checkOutput("cont_high_a",   high_a,   5);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abort_busy_a", busy_a, 0);
    checkOutput("abort_busy_b", busy_b, 0);
    vcnt_a = 0;
    repeat (30) @(negedge clk);
    checkOutput("abort_no_valid",   vcnt_a,   0);
    checkOutput("abort_period_kept", period_a, 10);

    // Timeout with sig_in held low.
    wave_en = 1'b0; sig_in = 1'b0;
    repeat (10) @(negedge clk);
    vcnt_a = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    ta = -1; tb = -1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (timeout_a && ta < 0) ta = k;
      if (timeout_b && tb < 0) tb = k;
    end
    checkOutput("tmo_cycle_a",     ta,       100);
    checkOutput("tmo_cycle_b",     tb,       10);
    checkOutput("tmo_no_valid",    vcnt_a,   0);
    checkOutput("tmo_busy_a",      busy_a,   0);
    checkOutput("tmo_period_kept", period_a, 10);

    // Duty test 3/9 with an ignored re-start.
    set_wave(3, 9);
    repeat (20) @(negedge clk);
    vcnt_a = 0; vcnt_b = 0; tcnt_b = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    checkOutput("duty_vcnt_a",  vcnt_a,   1);
    checkOutput("duty_period",  period_a, 12);
    checkOutput("duty_high",    high_a,   3);
    checkOutput("duty_busy_a",  busy_a,   0);
    checkOutput("duty_vcnt_b",  vcnt_b,   0);
    checkOutput("duty_tmo_b",   tcnt_b,   1);

    // Reset in the middle of a measurement.
    set_wave(5, 5);
    repeat (20) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    checkOutput("prerst_period", period_a, 10);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_period_a", period_a, 0);
    checkOutput("rst_high_a",   high_a,   0);
    checkOutput("rst_busy_a",   busy_a,   0);
    checkOutput("rst_valid_a",  valid_a,  0);
    checkOutput("rst_period_b", period_b, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    vcnt_a = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    checkOutput("postrst_vcnt",   vcnt_a,   1);
    checkOutput("postrst_period", period_a, 10);
    checkOutput("postrst_high",   high_a,   5);

    // Randomized waves and control; the per-cycle comparison does the checking.
    for (int iter = 0; iter < 60; iter++) begin
      set_wave($urandom_range(1, 8), $urandom_range(1, 8));
      if (iter % 5 == 4) noise = 1'b1;
      repeat ($urandom_range(0, 5)) @(negedge clk);
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(5, 40)) @(negedge clk);
      r = $urandom_range(0, 9);
      if (r == 0) begin
        applyStimulus(1'b0, 1'b0, 1'b1);
      end else if (r == 1) begin
        applyStimulus(1'b1, 1'b1, 1'b1);
      end else if (r == 2) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
